// File: rtl/ice51_uart_rx_pkg.sv
// Shared definitions for the ice51 UART receive path: bit timing, data width, FSM states.
package ice51_uart_rx_pkg;

    localparam int unsigned UartClksPerBit12M115K2 = 104;
    localparam int unsigned UartDataW              = 8;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxBreak
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/ice51_uart_rx_sync.sv
// N-stage flop synchroniser with a configurable reset value, for asynchronous input pins.
module ice51_uart_rx_sync #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= {Stages{ResetVal}};
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
        end
    end

    assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/ice51_uart_rx.sv
// 8N1 LSB-first UART receiver feeding the ice51 code loader and serial input register.
// Define ICE51_UART_RX_MAJORITY_EN for 3-sample majority voting at each bit sample point.
module ice51_uart_rx
    import ice51_uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UartClksPerBit12M115K2,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_uart_rx,
    output logic [UartDataW-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int unsigned CntW    = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitCntW = $clog2(UartDataW);
`ifdef ICE51_UART_RX_MAJORITY_EN
    localparam int unsigned SampleOff = 1;
`else
    localparam int unsigned SampleOff = 0;
`endif
    localparam logic [CntW-1:0]    HalfCnt = CntW'(CLKS_PER_BIT / 2 - 1 + SampleOff);
    localparam logic [CntW-1:0]    FullCnt = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitCntW-1:0] LastBit = BitCntW'(UartDataW - 1);

    logic rx_s;
    logic sample_bit;

    rx_state_e              state_q;
    logic [CntW-1:0]        clk_cnt_q;
    logic [BitCntW-1:0]     bit_cnt_q;
    logic [UartDataW-1:0]   shift_q;
    logic [UartDataW-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;

    ice51_uart_rx_sync #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b1)
    ) u_sync (
        .clk_i  (i_clk),
        .rst_ni (i_nrst),
        .d_i    (i_uart_rx),
        .q_o    (rx_s)
    );

`ifdef ICE51_UART_RX_MAJORITY_EN
    // hist_q[0] is the mid sample, hist_q[1] mid-1; the vote resolves on mid+1.
    logic [1:0] hist_q;

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            hist_q <= 2'b11;
        end else begin
            hist_q <= {hist_q[0], rx_s};
        end
    end

    assign sample_bit = majority3(rx_s, hist_q[0], hist_q[1]);
`else
    assign sample_bit = rx_s;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            state_q   <= RxIdle;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                RxIdle: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= RxStart;
                        busy_q  <= 1'b1;
                    end
                end
                RxStart: begin
                    if (clk_cnt_q == HalfCnt) begin
                        clk_cnt_q <= '0;
                        if (sample_bit) begin
                            state_q <= RxIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RxData;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RxData: begin
                    if (clk_cnt_q == FullCnt) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {sample_bit, shift_q[UartDataW-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            state_q <= RxStop;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RxStop: begin
                    // Leave mid-stop so a zero-gap following start edge is not missed.
                    if (clk_cnt_q == FullCnt) begin
                        clk_cnt_q <= '0;
                        if (sample_bit) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= RxIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= RxBreak;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + 1'b1;
                    end
                end
                RxBreak: begin
                    if (rx_s) begin
                        state_q <= RxIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RxIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_ice51_uart_rx.sv
// Scoreboard bench for ice51_uart_rx: frames are queued as expected strobes, a monitor checks them.
module tb_ice51_uart_rx;

    localparam int Cpb = 104;
`ifdef ICE51_UART_RX_MAJORITY_EN
    localparam int MajOff = 1;
`else
    localparam int MajOff = 0;
`endif
    // Pin start edge to strobe: receiver latency plus the two synchroniser stages.
    localparam int Lat = 1 + Cpb / 2 + 9 * Cpb + 2 + MajOff;

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       busy;

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ice51_uart_rx dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_uart_rx   (rx),
        .o_data      (data),
        .o_valid     (valid),
        .o_frame_err (ferr),
        .o_busy      (busy)
    );

    typedef struct {
        logic       ferr;
        logic [7:0] data;
        longint     due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model_data = 8'h00;
    int         checks     = 0;
    int         failures   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest queued expectation, including its timing.
    always @(negedge clk) begin
        if (nrst && (valid || ferr)) begin
            exp_t e;
            check("strobe_exclusive", 64'(valid & ferr), 64'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got valid=%0b frame_err=%0b data=%0h expected none",
                         valid, ferr, data);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", 64'(ferr), 64'(e.ferr));
                check("strobe_data", 64'(data), 64'(e.data));
                check("strobe_cycle", cyc, e.due);
            end
        end
    end

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * Cpb) @(negedge clk);
    endtask

    // One 8N1 frame; glitch_bit >= 0 inverts that data bit for one clock at its midpoint.
    task automatic send(input logic [7:0] b, input logic stop, input int glitch_bit);
        exp_t e;
        if (stop) model_data = b;
        e.ferr = !stop;
        e.data = model_data;
        e.due  = cyc + Lat;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            if (k == glitch_bit) begin
                repeat (Cpb / 2) @(negedge clk);
                rx = ~b[k];
                @(negedge clk);
                rx = b[k];
                repeat (Cpb - Cpb / 2 - 1) @(negedge clk);
            end else begin
                repeat (Cpb) @(negedge clk);
            end
        end
        rx = stop;
        repeat (Cpb) @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: got %0d strobes outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        logic       good;
        logic [7:0] abort_byte;

        repeat (5) @(negedge clk);
        check("reset_data", 64'(data), 64'h00);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_ferr", 64'(ferr), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        nrst = 1'b1;
        idle_bits(1);

        // Bad stop held low, then a good byte; o_data must stay 0x00 at the error.
        send(8'h3C, 1'b0, -1);
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        idle_bits(2);
        send(8'h7E, 1'b1, -1);
        idle_bits(2);
        wait_drain();

        send(8'h55, 1'b1, -1);
        idle_bits(1);

        send(8'h00, 1'b1, -1);
        send(8'hFF, 1'b1, -1);
        send(8'hA5, 1'b1, -1);
        idle_bits(1);
        wait_drain();

        // Short low pulse must be rejected as a glitch.
        rx = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_high", 64'(busy), 64'd1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_busy_low", 64'(busy), 64'd0);
        check("glitch_data_kept", 64'(data), 64'(model_data));

`ifdef ICE51_UART_RX_MAJORITY_EN
        send(8'h00, 1'b1, 3);
        idle_bits(1);
        wait_drain();
`endif

        for (int i = 0; i < 16; i++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send(b, good, -1);
            if (!good) idle_bits(2);
            else idle_bits(int'($urandom_range(0, 2)));
        end
        wait_drain();

        // Reset during bit 4 of 0x81 aborts the frame silently.
        abort_byte = 8'h81;
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            rx = abort_byte[k];
            repeat (Cpb / 2) @(negedge clk);
            if (k < 4) repeat (Cpb - Cpb / 2) @(negedge clk);
        end
        check("abort_busy_midframe", 64'(busy), 64'd1);
        nrst = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_reset_data", 64'(data), 64'h00);
        check("abort_reset_busy", 64'(busy), 64'd0);
        nrst       = 1'b1;
        model_data = 8'h00;
        idle_bits(2);
        send(8'h42, 1'b1, -1);
        idle_bits(1);
        wait_drain();
        check("final_busy", 64'(busy), 64'd0);
        check("final_data", 64'(data), 64'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
